// File: rtl/hybrid_bp_pkg.sv
// hybrid_bp_pkg: shared types and constants for the hybrid BATAGE/BFNP predictor
package hybrid_bp_pkg;

    localparam int BATAGE_IDX    = 0;
    localparam int BFNP_IDX      = 1;
    localparam int CHOOSER_FLOOR = 0;
    localparam int CHOOSER_STEP  = 1;

    localparam int DEF_NUM_PRED = 2;
    localparam int DEF_CTR_W    = 2;
    localparam int DEF_PC_W     = 32;

    // Per-branch metadata carried from prediction to resolution (default sizing).
    typedef struct packed {
        logic                         pred;
        logic [DEF_NUM_PRED-1:0]      comp_pred;
        logic [$clog2(DEF_NUM_PRED)-1:0] pick;
        logic [DEF_CTR_W-1:0]         ctr;
        logic [DEF_PC_W-1:0]          pc;
    } meta_t;

    // Saturation ceiling of an unsigned chooser counter of width w.
    function automatic int chooser_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/chooser_ctr_update.sv
// chooser_ctr_update: saturating chooser-counter rule, shared with the chooser table write path
module chooser_ctr_update
    import hybrid_bp_pkg::*;
#(
    parameter int CTR_W = 2
) (
    input  logic [CTR_W-1:0] ctr_i,
    input  logic             batage_i,
    input  logic             bfnp_i,
    input  logic             dir_i,
    output logic [CTR_W-1:0] ctr_o
);

    localparam logic [CTR_W-1:0] CTR_MAX = CTR_W'(chooser_max(CTR_W));
    localparam logic [CTR_W-1:0] CTR_MIN = CTR_W'(CHOOSER_FLOOR);
    localparam logic [CTR_W-1:0] STEP    = CTR_W'(CHOOSER_STEP);

    // Agreement leaves the counter alone; otherwise it moves toward the component that was right.
    always_comb begin
        ctr_o = ctr_i;
        if (batage_i != bfnp_i)
            ctr_o = (bfnp_i == dir_i) ? ((ctr_i == CTR_MAX) ? ctr_i : ctr_i + STEP)
                                      : ((ctr_i == CTR_MIN) ? ctr_i : ctr_i - STEP);
    end

endmodule

// File: rtl/hybrid_meta_pipe.sv
// hybrid_meta_pipe: predictor metadata pipeline to resolution; PC storage only with HYBRID_META_PIPE_PC_EN
module hybrid_meta_pipe
    import hybrid_bp_pkg::*;
#(
    parameter  int DEPTH    = 3,
    parameter  int NUM_PRED = 2,
    parameter  int CTR_W    = 2,
    parameter  int PC_W     = 32,
    localparam int PICK_W   = $clog2(NUM_PRED)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                flush,
    input  logic                in_valid,
    input  logic                in_pred,
    input  logic [NUM_PRED-1:0] in_comp_pred,
    input  logic [PICK_W-1:0]   in_pick,
    input  logic [CTR_W-1:0]    in_ctr,
    input  logic [PC_W-1:0]     in_pc,
    input  logic                resolve_dir,
    output logic                out_valid,
    output logic                out_pred,
    output logic [NUM_PRED-1:0] out_comp_pred,
    output logic [PICK_W-1:0]   out_pick,
    output logic [CTR_W-1:0]    out_ctr,
    output logic [PC_W-1:0]     out_pc,
    output logic                upd_valid,
    output logic [CTR_W-1:0]    upd_ctr,
    output logic [PC_W-1:0]     upd_pc,
    output logic                upd_mispredict,
    output logic [NUM_PRED-1:0] upd_comp_wrong
);

    // Same layout as meta_t, sized by this instance; the PC field exists only when enabled.
    typedef struct packed {
        logic                pred;
        logic [NUM_PRED-1:0] comp_pred;
        logic [PICK_W-1:0]   pick;
        logic [CTR_W-1:0]    ctr;
`ifdef HYBRID_META_PIPE_PC_EN
        logic [PC_W-1:0]     pc;
`endif
    } stage_t;

    logic   [DEPTH-1:0] valid_q, valid_d;
    stage_t [DEPTH-1:0] stage_q, stage_d;
    stage_t             in_stage, oldest;
    logic               retire;
    logic [CTR_W-1:0]   new_ctr;
    logic               upd_valid_q, upd_mispredict_q;
    logic [CTR_W-1:0]   upd_ctr_q;
    logic [NUM_PRED-1:0] upd_comp_wrong_q;

    assign oldest = stage_q[DEPTH-1];
    assign retire = !stall && valid_q[DEPTH-1];

    // Pack the incoming prediction into a stage payload.
    always_comb begin
        in_stage           = '0;
        in_stage.pred      = in_pred;
        in_stage.comp_pred = in_comp_pred;
        in_stage.pick      = in_pick;
        in_stage.ctr       = in_ctr;
`ifdef HYBRID_META_PIPE_PC_EN
        in_stage.pc        = in_pc;
`endif
    end

    // Shift one stage per unstalled cycle; flush kills every valid bit, including the incoming one.
    always_comb begin
        valid_d = valid_q;
        stage_d = stage_q;
        if (!stall) begin
            valid_d[0] = in_valid;
            stage_d[0] = in_stage;
            for (int k = 1; k < DEPTH; k++) begin
                valid_d[k] = valid_q[k-1];
                stage_d[k] = stage_q[k-1];
            end
        end
        if (flush) valid_d = '0;
    end

    // Stage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            stage_q <= '0;
        end else begin
            valid_q <= valid_d;
            stage_q <= stage_d;
        end
    end

    chooser_ctr_update #(.CTR_W(CTR_W)) u_chooser (
        .ctr_i    (oldest.ctr),
        .batage_i (oldest.comp_pred[BATAGE_IDX]),
        .bfnp_i   (oldest.comp_pred[BFNP_IDX]),
        .dir_i    (resolve_dir),
        .ctr_o    (new_ctr)
    );

    // Capture the retiring entry's chooser update; the valid flag is a one-cycle pulse per retire.
    always_ff @(posedge clk) begin
        if (rst) begin
            upd_valid_q      <= 1'b0;
            upd_ctr_q        <= '0;
            upd_mispredict_q <= 1'b0;
            upd_comp_wrong_q <= '0;
        end else begin
            upd_valid_q <= retire;
            if (retire) begin
                upd_ctr_q        <= new_ctr;
                upd_mispredict_q <= oldest.pred ^ resolve_dir;
                upd_comp_wrong_q <= oldest.comp_pred ^ {NUM_PRED{resolve_dir}};
            end
        end
    end

`ifdef HYBRID_META_PIPE_PC_EN
    logic [PC_W-1:0] upd_pc_q;

    // PC of the retiring entry.
    always_ff @(posedge clk) begin
        if (rst) upd_pc_q <= '0;
        else if (retire) upd_pc_q <= oldest.pc;
    end

    assign out_pc = oldest.pc;
    assign upd_pc = upd_pc_q;
`else
    logic unused_pc;
    assign unused_pc = ^in_pc;
    assign out_pc    = '0;
    assign upd_pc    = '0;
`endif

    assign out_valid      = valid_q[DEPTH-1];
    assign out_pred       = oldest.pred;
    assign out_comp_pred  = oldest.comp_pred;
    assign out_pick       = oldest.pick;
    assign out_ctr        = oldest.ctr;
    assign upd_valid      = upd_valid_q;
    assign upd_ctr        = upd_ctr_q;
    assign upd_mispredict = upd_mispredict_q;
    assign upd_comp_wrong = upd_comp_wrong_q;

endmodule
